time_mon_tab: RTL

TIME_MON_TAB -- requirements
Module: time_mon_tab

---
 rtl/time_mon_pkg.sv | 20 ++
 rtl/time_mon_ch.sv | 79 +++++++
 rtl/time_mon_tab.sv | 87 ++++++++
 3 files changed

// File: rtl/time_mon_pkg.sv
// Shared types and parameter defaults for the interval timing monitor.
package time_mon_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    typedef enum logic [1:0] {
        SEL_LAST = 2'd0,
        SEL_MIN  = 2'd1,
        SEL_MAX  = 2'd2,
        SEL_CNT  = 2'd3
    } rd_sel_e;

    localparam int DEF_NUM_CH = 3;
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_NUM_W  = 16;

endpackage

// File: rtl/time_mon_ch.sv
// One timing channel: IDLE/RUN FSM, saturating interval counter,
// last/min/max/count statistics and sticky overflow/error flags.
module time_mon_ch
    import time_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             ovf,
    output logic             err,
    output logic [CNT_W-1:0] last_val,
    output logic [CNT_W-1:0] min_val,
    output logic [CNT_W-1:0] max_val,
    output logic [NUM_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [NUM_W-1:0] NUM_MAX = '1;

    ch_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             rec;

    assign busy = (state == RUN);
    assign rec  = (state == RUN) && stop;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state    <= IDLE;
            cnt      <= '0;
            last_val <= '0;
            min_val  <= '1;
            max_val  <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && en) begin
                        state <= RUN;
                        cnt   <= CNT_W'(1);
                    end else if (stop && !start) begin
                        err <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == CNT_MAX) ovf <= 1'b1;
                    // a same-cycle start re-arms right after recording
                    if (stop) begin
                        if (start && en) begin
                            cnt <= CNT_W'(1);
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (rec) begin
                last_val <= cnt;
                if (cnt < min_val) min_val <= cnt;
                if (cnt > max_val) max_val <= cnt;
                if (count != NUM_MAX) count <= count + NUM_W'(1);
            end
        end
    end

endmodule

// File: rtl/time_mon_tab.sv
// Multi-channel interval monitor: NUM_CH timing channels plus a
// registered one-cycle-latency statistics read port.
module time_mon_tab
    import time_mon_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int NUM_W  = DEF_NUM_W,
    localparam int RW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_CH-1:0] ch_start,
    input  logic [NUM_CH-1:0] ch_stop,
    input  logic              rd_req,
    input  logic [RW-1:0]     rd_ch,
    input  logic [1:0]        rd_sel,
    output logic              rd_vld,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] ovf,
    output logic [NUM_CH-1:0] err
);

    localparam int DEPTH = 1 << RW;

    logic [CNT_W-1:0] last_a [DEPTH];
    logic [CNT_W-1:0] min_a  [DEPTH];
    logic [CNT_W-1:0] max_a  [DEPTH];
    logic [CNT_W-1:0] cnt_a  [DEPTH];
    logic [CNT_W-1:0] sel_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ch
        if (i < NUM_CH) begin : g_real
            logic [NUM_W-1:0] n;
            time_mon_ch #(
                .CNT_W (CNT_W),
                .NUM_W (NUM_W)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .en       (en),
                .clr      (clr),
                .start    (ch_start[i]),
                .stop     (ch_stop[i]),
                .busy     (busy[i]),
                .ovf      (ovf[i]),
                .err      (err[i]),
                .last_val (last_a[i]),
                .min_val  (min_a[i]),
                .max_val  (max_a[i]),
                .count    (n)
            );
            assign cnt_a[i] = CNT_W'(n);
        end else begin : g_pad
            // unpopulated channel slots read back as zero
            assign last_a[i] = '0;
            assign min_a[i]  = '0;
            assign max_a[i]  = '0;
            assign cnt_a[i]  = '0;
        end
    end

    always_comb begin
        sel_data = '0;
        unique case (rd_sel_e'(rd_sel))
            SEL_LAST: sel_data = last_a[rd_ch];
            SEL_MIN:  sel_data = min_a[rd_ch];
            SEL_MAX:  sel_data = max_a[rd_ch];
            SEL_CNT:  sel_data = cnt_a[rd_ch];
            default:  sel_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_vld <= rd_req;
            if (rd_req) rd_data <= sel_data;
        end
    end

endmodule
